// File: rtl/vault_reader_if.sv
// Bus bundle for vault_reader: control, register-file read port and output stream.
// Define VAULT_READER_PARITY_EN to add the m_parity output.
interface vault_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] burst_len;
    logic              busy;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;
    logic              done;
`ifdef VAULT_READER_PARITY_EN
    logic              m_parity;
`endif

    modport master (
        input  start, start_addr, burst_len, rdata, m_ready,
`ifdef VAULT_READER_PARITY_EN
        output m_parity,
`endif
        output busy, raddr, m_valid, m_data, m_addr, m_last, done
    );

    modport slave (
        output start, start_addr, burst_len, rdata, m_ready,
`ifdef VAULT_READER_PARITY_EN
        input  m_parity,
`endif
        input  busy, raddr, m_valid, m_data, m_addr, m_last, done
    );
endinterface

// File: rtl/vault_reader.sv
// Burst read master for a small register file, streaming snapshots out on valid/ready.
// Define VAULT_READER_PARITY_EN to register an even-parity bit alongside m_data.
module vault_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    vault_reader_if.master bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              done_q, done_d;
    logic              handshake;
`ifdef VAULT_READER_PARITY_EN
    logic              m_parity_q, m_parity_d;
`endif

    assign handshake = m_valid_q && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            raddr_q    <= '0;
            rem_q      <= '0;
            m_data_q   <= '0;
            m_addr_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef VAULT_READER_PARITY_EN
            m_parity_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            rem_q      <= rem_d;
            m_data_q   <= m_data_d;
            m_addr_q   <= m_addr_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            done_q     <= done_d;
`ifdef VAULT_READER_PARITY_EN
            m_parity_q <= m_parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StFetch;
            StFetch: state_d = StSend;
            StSend:  if (handshake) state_d = m_last_q ? StIdle : StFetch;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        raddr_d    = raddr_q;
        rem_d      = rem_q;
        m_data_d   = m_data_q;
        m_addr_d   = m_addr_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        done_d     = 1'b0;
`ifdef VAULT_READER_PARITY_EN
        m_parity_d = m_parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    raddr_d = bus.start_addr;
                    rem_d   = bus.burst_len;
                end
            end
            StFetch: begin
                // Snapshot is taken here; later writes to the file do not affect m_data.
                m_data_d   = bus.rdata;
                m_addr_d   = raddr_q;
                m_last_d   = (rem_q == '0);
                m_valid_d  = 1'b1;
`ifdef VAULT_READER_PARITY_EN
                m_parity_d = ^bus.rdata;
`endif
            end
            StSend: begin
                if (handshake) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        raddr_d = (raddr_q == ADDR_W'(DEPTH - 1)) ? '0 : raddr_q + ADDR_W'(1);
                        rem_d   = rem_q - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != StIdle);
        bus.raddr    = raddr_q;
        bus.m_valid  = m_valid_q;
        bus.m_data   = m_data_q;
        bus.m_addr   = m_addr_q;
        bus.m_last   = m_last_q;
        bus.done     = done_q;
`ifdef VAULT_READER_PARITY_EN
        bus.m_parity = m_parity_q;
`endif
    end
endmodule

// File: tb/tb_vault_reader.sv
// Directed self-checking bench for vault_reader with a behavioural 4x8 register file.
module tb_vault_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] regs [4];
    int n_checks = 0;
    int n_errors = 0;

    vault_reader_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    vault_reader #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rdata = regs[bus.raddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for m_valid, checks the word, then lets one edge pass for the handshake.
    task automatic expect_word(input string tag, input logic [7:0] d, input logic [1:0] a,
                               input logic l);
        int n = 0;
        while (bus.m_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, bus.m_valid, 1);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_data"}, bus.m_data, d);
        chk({tag, "_addr"}, bus.m_addr, a);
        chk({tag, "_last"}, bus.m_last, l);
        tick();
    endtask

    task automatic pulse_start(input logic [1:0] a, input logic [1:0] len);
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.burst_len  = len;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
        bus.start = 1'b0; bus.start_addr = '0; bus.burst_len = '0; bus.m_ready = 1'b1;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_raddr", bus.raddr, 0);
        chk("rst_mdata", bus.m_data, 0);
        chk("rst_maddr", bus.m_addr, 0);

        // Full burst 0..3, latency check
        pulse_start(2'd0, 2'd3);
        chk("lat_busy", bus.busy, 1);
        chk("lat_valid_fetch", bus.m_valid, 0);
        tick();
        chk("lat_valid", bus.m_valid, 1);
        expect_word("b0w0", 8'h11, 2'd0, 1'b0);
        expect_word("b0w1", 8'h22, 2'd1, 1'b0);
        expect_word("b0w2", 8'h33, 2'd2, 1'b0);
        expect_word("b0w3", 8'h44, 2'd3, 1'b1);
        chk("b0_done", bus.done, 1);
        chk("b0_idle", bus.busy, 0);
        chk("b0_valid_low", bus.m_valid, 0);
        tick();
        chk("b0_done_pulse", bus.done, 0);

        // Wrap 3 -> 0, then start in the same cycle as done
        pulse_start(2'd3, 2'd1);
        expect_word("wrap0", 8'h44, 2'd3, 1'b0);
        expect_word("wrap1", 8'h11, 2'd0, 1'b1);
        chk("wrap_done", bus.done, 1);
        pulse_start(2'd2, 2'd0);
        chk("sd_busy", bus.busy, 1);
        expect_word("sd0", 8'h33, 2'd2, 1'b1);
        chk("sd_done", bus.done, 1);
        tick();

        // Backpressure with snapshot held across a write
        bus.m_ready = 1'b0;
        pulse_start(2'd2, 2'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.m_valid, 1);
            chk("bp_data", bus.m_data, 8'h33);
            if (i == 2) regs[2] = 8'hAA;
            tick();
        end
        chk("bp_done_early", bus.done, 0);
        bus.m_ready = 1'b1;
        tick();
        chk("bp_done", bus.done, 1);
        chk("bp_valid_low", bus.m_valid, 0);
        regs[2] = 8'h33;
        tick();

        // Start mid-burst is ignored; write to a not-yet-fetched address is observed
        pulse_start(2'd0, 2'd3);
        bus.start = 1'b1; bus.start_addr = 2'd2; bus.burst_len = 2'd0;
        tick();
        bus.start = 1'b0;
        regs[3] = 8'h5C;
        expect_word("ign0", 8'h11, 2'd0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_word("ign1", 8'h22, 2'd1, 1'b0);
        expect_word("ign2", 8'h33, 2'd2, 1'b0);
        expect_word("ign3", 8'h5C, 2'd3, 1'b1);
        chk("ign_done", bus.done, 1);
        tick();
        chk("ign_no_extra", bus.busy, 0);
        chk("ign_no_valid", bus.m_valid, 0);
        regs[3] = 8'h44;

        // Reset while SEND holds the second word
        pulse_start(2'd0, 2'd3);
        expect_word("rs0", 8'h11, 2'd0, 1'b0);
        bus.m_ready = 1'b0;
        tick();
        chk("rs_w1_data", bus.m_data, 8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_busy", bus.busy, 0);
        chk("rs_valid", bus.m_valid, 0);
        chk("rs_last", bus.m_last, 0);
        chk("rs_raddr", bus.raddr, 0);
        chk("rs_done", bus.done, 0);
        bus.m_ready = 1'b1;
        tick();
        chk("rs_done_later", bus.done, 0);
        pulse_start(2'd1, 2'd0);
        expect_word("rs_fresh", 8'h22, 2'd1, 1'b1);
        chk("rs_fresh_done", bus.done, 1);
        tick();

`ifdef VAULT_READER_PARITY_EN
        regs[0] = 8'h07; regs[1] = 8'h03;
        pulse_start(2'd0, 2'd1);
        tick();
        chk("par0", bus.m_parity, 1);
        expect_word("par0w", 8'h07, 2'd0, 1'b0);
        tick();
        chk("par1", bus.m_parity, 0);
        expect_word("par1w", 8'h03, 2'd1, 1'b1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
